// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: hex digits, error message, blank and lamp test.
// Define SEG_BLINK_EN to enable per-digit blinking driven by a frame-counting blink phase.
module seg_scan_ctrl #(
    parameter int NUM_DIG      = 4,
    parameter int CLK_DIV      = 1,
    parameter int BLINK_FRAMES = 25
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4*NUM_DIG-1:0] digits,
    input  logic [NUM_DIG-1:0]   dp_in,
    input  logic [NUM_DIG-1:0]   blink,
    input  logic [1:0]           mode,
    output logic [6:0]           seg,
    output logic                 dp,
    output logic [NUM_DIG-1:0]   dig,
    output logic                 frame_tick
);

    localparam int IDX_W = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam logic [15:0]      DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIG - 1);

    typedef enum logic [1:0] {
        MODE_DIGITS = 2'b00,
        MODE_ERROR  = 2'b01,
        MODE_BLANK  = 2'b10,
        MODE_LAMP   = 2'b11
    } mode_t;

    logic [15:0]        pre_cnt;
    logic [IDX_W-1:0]   idx;
    logic [2:0]         pos;
    logic               tick;
    logic               frame_end;
    mode_t              mode_sel;
    logic [3:0]         nibble;
    logic               dp_bit;
    logic               blink_bit;
    logic               hide;
    logic [6:0]         seg_nx;
    logic               dp_nx;
    logic [NUM_DIG-1:0] dig_nx;

    assign tick      = (pre_cnt == DIV_LAST);
    assign frame_end = tick && (idx == IDX_LAST);
    assign pos       = 3'(idx);
    assign mode_sel  = mode_t'(mode);

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1111110;
            4'h1: hex7 = 7'b0110000;
            4'h2: hex7 = 7'b1101101;
            4'h3: hex7 = 7'b1111001;
            4'h4: hex7 = 7'b0110011;
            4'h5: hex7 = 7'b1011011;
            4'h6: hex7 = 7'b1011111;
            4'h7: hex7 = 7'b1110000;
            4'h8: hex7 = 7'b1111111;
            4'h9: hex7 = 7'b1111011;
            4'hA: hex7 = 7'b1110111;
            4'hB: hex7 = 7'b0011111;
            4'hC: hex7 = 7'b1001110;
            4'hD: hex7 = 7'b0111101;
            4'hE: hex7 = 7'b1001111;
            default: hex7 = 7'b1000111;
        endcase
    endfunction

`ifdef SEG_BLINK_EN
    logic [7:0] blink_cnt;
    logic       blink_hidden;
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    // Phase flips on the tick that completes a frame, so the next frame sees the new phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt    <= '0;
            blink_hidden <= 1'b0;
        end else if (frame_end) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt    <= '0;
                blink_hidden <= ~blink_hidden;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end
`else
    logic blink_unused;
    assign blink_unused = ^blink;
`endif

    always_comb begin
        nibble    = '0;
        dp_bit    = 1'b0;
        blink_bit = 1'b0;
        dig_nx    = '1;
        for (int unsigned i = 0; i < NUM_DIG; i++) begin
            if (pos == 3'(i)) begin
                nibble                = digits[4*(NUM_DIG-1-i) +: 4];
                dp_bit                = dp_in[NUM_DIG-1-i];
`ifdef SEG_BLINK_EN
                blink_bit             = blink[NUM_DIG-1-i];
`endif
                dig_nx[NUM_DIG-1-i]   = 1'b0;
            end
        end
`ifdef SEG_BLINK_EN
        hide = blink_bit && blink_hidden;
`else
        hide = blink_bit;
`endif
        seg_nx = '0;
        dp_nx  = 1'b0;
        case (mode_sel)
            MODE_DIGITS: begin
                if (!hide) begin
                    seg_nx = hex7(nibble);
                    dp_nx  = dp_bit;
                end
            end
            MODE_ERROR: begin
                case (pos)
                    3'd0:    seg_nx = 7'b1001111;
                    3'd1:    seg_nx = 7'b0000101;
                    3'd2:    seg_nx = 7'b0000101;
                    3'd3:    seg_nx = 7'b0011101;
                    default: seg_nx = '0;
                endcase
            end
            MODE_BLANK: begin
                seg_nx = '0;
            end
            default: begin
                seg_nx = '1;
                dp_nx  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt    <= '0;
            idx        <= '0;
            seg        <= '0;
            dp         <= 1'b0;
            dig        <= '1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            if (tick) begin
                pre_cnt    <= '0;
                seg        <= seg_nx;
                dp         <= dp_nx;
                dig        <= dig_nx;
                frame_tick <= frame_end;
                idx        <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
        end
    end

endmodule
